// File: rtl/sm3_msg_pad.sv
// SM3 message padder and block sequencer: packs 32-bit big-endian words into 512-bit blocks,
// appends 0x80/zeros/bit-length, and chains the 256-bit state through an external sm3_core.
module sm3_msg_pad #(
  parameter logic [255:0] IV    = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e,
  parameter int           LEN_W = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [31:0]  i_word,
  input  logic         i_last,
  input  logic [2:0]   i_bytes,
  output logic         o_blk_start,
  output logic [511:0] o_blk_data,
  output logic [255:0] o_blk_vin,
  input  logic [255:0] i_blk_vout,
  input  logic         i_blk_done,
  output logic [255:0] o_hash,
  output logic         o_hash_valid
);

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_PAD  = 2'd1;
  localparam logic [1:0] S_HASH = 2'd2;

  localparam logic [31:0] PAD80 = 32'h8000_0000;

  logic [1:0]       state_q, state_d;
  logic [3:0]       ptr_q, ptr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [255:0]     chain_q, chain_d;
  logic [31:0]      words_q [16];
  logic [31:0]      words_d [16];
  logic             pend_q, pend_d;   // 0x80 still owed to the next buffer word
  logic             zf_q, zf_d;       // 0x80 sits in word 14/15: finish block with zeros
  logic             more_q, more_d;
  logic             tail_q, tail_d;
  logic             start_q, start_d;
  logic [255:0]     hash_q, hash_d;
  logic             hv_q, hv_d;
  logic [63:0]      len64;

  function automatic logic [31:0] last_word(input logic [31:0] w, input logic [2:0] b);
    logic [31:0] m;
    case (b)
      3'd0:    m = 32'h0000_0000;
      3'd1:    m = 32'hFF00_0000;
      3'd2:    m = 32'hFFFF_0000;
      3'd3:    m = 32'hFFFF_FF00;
      default: m = 32'hFFFF_FFFF;
    endcase
    last_word = w & m;
    if (b < 3'd4) last_word = last_word | (PAD80 >> {b, 3'b000});
  endfunction

  function automatic logic [5:0] byte_bits(input logic [2:0] b);
    byte_bits = (b >= 3'd4) ? 6'd32 : {b, 3'b000};
  endfunction

  assign len64 = 64'(cnt_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    chain_d = chain_q;
    words_d = words_q;
    pend_d  = pend_q;
    zf_d    = zf_q;
    more_d  = more_q;
    tail_d  = tail_q;
    start_d = 1'b0;
    hash_d  = hash_q;
    hv_d    = 1'b0;
    case (state_q)
      S_FILL: begin
        if (i_valid) begin
          ptr_d = ptr_q + 4'd1;
          if (!i_last) begin
            words_d[ptr_q] = i_word;
            cnt_d          = cnt_q + LEN_W'(32);
            if (ptr_q == 4'd15) begin
              state_d = S_HASH;
              start_d = 1'b1;
              more_d  = 1'b1;
              tail_d  = 1'b0;
            end
          end else begin
            words_d[ptr_q] = last_word(i_word, i_bytes);
            cnt_d          = cnt_q + LEN_W'(byte_bits(i_bytes));
            pend_d         = (i_bytes >= 3'd4);
            zf_d           = (ptr_q == 4'd14) && (i_bytes < 3'd4);
            if (ptr_q == 4'd15) begin
              // Block is full; padding (and possibly the 0x80) spills into a second block.
              state_d = S_HASH;
              start_d = 1'b1;
              more_d  = 1'b0;
              tail_d  = 1'b1;
              zf_d    = 1'b0;
            end else begin
              state_d = S_PAD;
            end
          end
        end
      end
      S_PAD: begin
        ptr_d  = ptr_q + 4'd1;
        pend_d = 1'b0;
        if (ptr_q < 4'd14) begin
          words_d[ptr_q] = pend_q ? PAD80 : 32'h0;
        end else if (ptr_q == 4'd14) begin
          if (pend_q) begin
            words_d[ptr_q] = PAD80;
            zf_d           = 1'b1;
          end else begin
            words_d[ptr_q] = len64[63:32];
          end
        end else begin
          words_d[ptr_q] = pend_q ? PAD80 : (zf_q ? 32'h0 : len64[31:0]);
          state_d = S_HASH;
          start_d = 1'b1;
          more_d  = 1'b0;
          tail_d  = pend_q | zf_q;
          zf_d    = 1'b0;
        end
      end
      S_HASH: begin
        if (i_blk_done) begin
          chain_d = i_blk_vout;
          ptr_d   = 4'd0;
          if (more_q) begin
            state_d = S_FILL;
          end else if (tail_q) begin
            state_d = S_PAD;
          end else begin
            state_d = S_FILL;
            hash_d  = i_blk_vout;
            hv_d    = 1'b1;
            chain_d = IV;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_FILL;
      ptr_q   <= '0;
      cnt_q   <= '0;
      chain_q <= IV;
      for (int i = 0; i < 16; i++) words_q[i] <= '0;
      pend_q  <= 1'b0;
      zf_q    <= 1'b0;
      more_q  <= 1'b0;
      tail_q  <= 1'b0;
      start_q <= 1'b0;
      hash_q  <= '0;
      hv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      chain_q <= chain_d;
      words_q <= words_d;
      pend_q  <= pend_d;
      zf_q    <= zf_d;
      more_q  <= more_d;
      tail_q  <= tail_d;
      start_q <= start_d;
      hash_q  <= hash_d;
      hv_q    <= hv_d;
    end
  end

  // The buffer is frozen during HASH, so it drives the core directly.
  always_comb begin
    o_blk_data = '0;
    for (int i = 0; i < 16; i++) o_blk_data[511-32*i -: 32] = words_q[i];
  end

  assign o_ready      = (state_q == S_FILL);
  assign o_blk_start  = start_q;
  assign o_blk_vin    = chain_q;
  assign o_hash       = hash_q;
  assign o_hash_valid = hv_q;

endmodule

// File: tb/tb_sm3_msg_pad.sv
// Bench for sm3_msg_pad: behavioural SM3 core stand-in plus a byte-level padding/digest reference.
module tb_sm3_msg_pad;

  localparam logic [255:0] IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [31:0]  i_word = '0;
  logic         i_last = 1'b0;
  logic [2:0]   i_bytes = '0;
  logic         o_blk_start;
  logic [511:0] o_blk_data;
  logic [255:0] o_blk_vin;
  logic [255:0] blk_vout = '0;
  logic         blk_done = 1'b0;
  logic [255:0] o_hash;
  logic         o_hash_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   msg[$];
  logic [511:0] exp_data[$];
  logic [255:0] exp_vin[$];
  logic [255:0] exp_hash[$];
  logic [511:0] log_data[$];
  logic [255:0] log_vin[$];
  logic [255:0] log_hash[$];

  bit           core_busy = 1'b0;
  int           core_cnt = 0;
  int           core_lat = 3;
  logic [255:0] core_res = '0;

  sm3_msg_pad dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_word(i_word), .i_last(i_last), .i_bytes(i_bytes),
    .o_blk_start(o_blk_start), .o_blk_data(o_blk_data), .o_blk_vin(o_blk_vin),
    .i_blk_vout(blk_vout), .i_blk_done(blk_done),
    .o_hash(o_hash), .o_hash_valid(o_hash_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    rotl = (n == 0) ? x : ((x << n) | (x >> (32 - n)));
  endfunction
  function automatic logic [31:0] p0(input logic [31:0] x);
    p0 = x ^ rotl(x, 9) ^ rotl(x, 17);
  endfunction
  function automatic logic [31:0] p1(input logic [31:0] x);
    p1 = x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

  // SM3 compression function CF(V, B)
  function automatic logic [255:0] sm3_cf(input logic [255:0] v, input logic [511:0] blk);
    logic [31:0] w [68];
    logic [31:0] w1 [64];
    logic [31:0] a, b, c, d, e, f, g, h, ss1, ss2, tt1, tt2, t;
    for (int j = 0; j < 16; j++) w[j] = blk[511-32*j -: 32];
    for (int j = 16; j < 68; j++)
      w[j] = p1(w[j-16] ^ w[j-9] ^ rotl(w[j-3], 15)) ^ rotl(w[j-13], 7) ^ w[j-6];
    for (int j = 0; j < 64; j++) w1[j] = w[j] ^ w[j+4];
    {a, b, c, d, e, f, g, h} = v;
    for (int j = 0; j < 64; j++) begin
      t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
      ss1 = rotl(rotl(a, 12) + e + rotl(t, j % 32), 7);
      ss2 = ss1 ^ rotl(a, 12);
      if (j < 16) begin
        tt1 = (a ^ b ^ c) + d + ss2 + w1[j];
        tt2 = (e ^ f ^ g) + h + ss1 + w[j];
      end else begin
        tt1 = ((a & b) | (a & c) | (b & c)) + d + ss2 + w1[j];
        tt2 = ((e & f) | (~e & g)) + h + ss1 + w[j];
      end
      d = c; c = rotl(b, 9); b = a; a = tt1;
      h = g; g = rotl(f, 19); f = e; e = p0(tt2);
    end
    sm3_cf = {a, b, c, d, e, f, g, h} ^ v;
  endfunction

  // Core stand-in and output monitor, both away from the DUT's active edge.
  always @(negedge clk) begin
    blk_done = 1'b0;
    if (o_hash_valid) log_hash.push_back(o_hash);
    if (core_busy) begin
      if (core_cnt <= 1) begin
        blk_done  = 1'b1;
        blk_vout  = core_res;
        core_busy = 1'b0;
      end else begin
        core_cnt = core_cnt - 1;
      end
    end else if (o_blk_start) begin
      core_busy = 1'b1;
      core_cnt  = core_lat;
      core_res  = sm3_cf(o_blk_vin, o_blk_data);
    end
    if (o_blk_start) begin
      log_data.push_back(o_blk_data);
      log_vin.push_back(o_blk_vin);
    end
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] req);
    n_tests++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, req);
    end
  endtask

  function automatic logic [511:0] get_d(input int i);
    get_d = (i < log_data.size()) ? log_data[i] : '0;
  endfunction
  function automatic logic [255:0] get_h(input int i);
    get_h = (i < log_hash.size()) ? log_hash[i] : '0;
  endfunction

  // Reference: textbook SM3 padding over bytes, then chained compression.
  task automatic model_msg();
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] blk;
    logic [255:0] ch;
    p = msg;
    bits = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(8'(bits >> (8 * k)));
    ch = IV;
    for (int bi = 0; bi < p.size() / 64; bi++) begin
      for (int k = 0; k < 64; k++) blk[511-8*k -: 8] = p[64*bi+k];
      exp_data.push_back(blk);
      exp_vin.push_back(ch);
      ch = sm3_cf(ch, blk);
    end
    exp_hash.push_back(ch);
  endtask

  task automatic send_word(input logic [31:0] w, input logic l, input logic [2:0] nb);
    bit acc;
    i_valid = 1'b1; i_word = w; i_last = l; i_bytes = nb;
    acc = 1'b0;
    for (int t = 0; t < 400 && !acc; t++) begin
      acc = o_ready;
      @(negedge clk);
    end
    chk("word_accepted", 512'(acc), 512'd1);
  endtask

  // mode 0: full final word, 1: empty tail word, 2: random choice (only when length is a multiple of 4)
  task automatic send_msg(input int mode);
    int n, full, rem;
    bit empty_tail;
    logic [31:0] w;
    n = msg.size(); full = n / 4; rem = n % 4;
    empty_tail = (n == 0) || (rem == 0 && (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)));
    for (int i = 0; i < full; i++) begin
      w = {msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]};
      send_word(w, (i == full - 1) && rem == 0 && !empty_tail, 3'd4);
    end
    if (rem != 0 || empty_tail) begin
      w = $urandom;
      for (int k = 0; k < rem; k++) w[31-8*k -: 8] = msg[4*full+k];
      send_word(w, 1'b1, 3'(rem));
    end
  endtask

  task automatic idle();
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic wait_hashes(input int n);
    for (int t = 0; t < 6000 && log_hash.size() < n; t++) @(negedge clk);
    repeat (8) @(negedge clk);
  endtask

  task automatic check_logs(input string tag);
    chk({tag, "_nblocks"}, 512'(log_data.size()), 512'(exp_data.size()));
    for (int i = 0; i < exp_data.size(); i++) begin
      chk({tag, "_blkdata"}, get_d(i), exp_data[i]);
      chk({tag, "_blkvin"}, 512'((i < log_vin.size()) ? log_vin[i] : 256'h0), 512'(exp_vin[i]));
    end
    chk({tag, "_nhash"}, 512'(log_hash.size()), 512'(exp_hash.size()));
    for (int i = 0; i < exp_hash.size(); i++) chk({tag, "_digest"}, 512'(get_h(i)), 512'(exp_hash[i]));
    exp_data.delete(); exp_vin.delete(); exp_hash.delete();
    log_data.delete(); log_vin.delete(); log_hash.delete();
  endtask

  task automatic make_abc();
    msg.delete(); msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
  endtask
  task automatic make_abcd16();
    msg.delete();
    for (int i = 0; i < 16; i++) begin
      msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63); msg.push_back(8'h64);
    end
  endtask
  task automatic make_rand(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
  endtask

  initial begin
    logic [511:0] d0, d1;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 512'(o_ready), 512'd1);
    chk("rst_start", 512'(o_blk_start), 512'd0);
    chk("rst_data", o_blk_data, 512'd0);
    chk("rst_vin", 512'(o_blk_vin), 512'(IV));
    chk("rst_hash", 512'(o_hash), 512'd0);
    chk("rst_hvalid", 512'(o_hash_valid), 512'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // "abc"
    core_lat = 3;
    make_abc(); model_msg(); send_msg(0); idle(); wait_hashes(1);
    chk("t1_block", get_d(0), {32'h61626380, 448'h0, 32'h00000018});
    chk("t1_digest", 512'(get_h(0)), 512'(256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0));
    check_logs("t1");

    // 64 bytes, final word full
    core_lat = 5;
    make_abcd16(); model_msg(); send_msg(0); idle(); wait_hashes(1);
    chk("t2_block2", get_d(1), {32'h80000000, 448'h0, 32'h00000200});
    chk("t2_digest", 512'(get_h(0)), 512'(256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732));
    check_logs("t2");

    // Empty message
    make_rand(0); model_msg(); send_msg(0); idle(); wait_hashes(1);
    chk("t3_block", get_d(0), {32'h80000000, 480'h0});
    chk("t3_digest", 512'(get_h(0)), 512'(256'h1ab21d83_55cfa17f_8e611948_31e81a8f_22bec8c7_28fefb74_7ed035eb_5082aa2b));
    check_logs("t3");

    // 14 full words: 0x80 lands in word 14, length spills to a second block
    core_lat = 2;
    make_rand(56); model_msg(); send_msg(0); idle(); wait_hashes(1);
    d0 = get_d(0); d1 = get_d(1);
    chk("t4_b1_w14", 512'(d0[63:32]), 512'(32'h80000000));
    chk("t4_b1_w15", 512'(d0[31:0]), 512'd0);
    chk("t4_b2", d1, {448'h0, 64'h1C0});
    check_logs("t4");

    // Reset while the first block of a 64-byte message is being hashed
    core_lat = 30;
    make_abcd16(); send_msg(0);
    rst_n = 1'b0; idle();
    @(negedge clk);
    chk("t5_ready", 512'(o_ready), 512'd1);
    chk("t5_start", 512'(o_blk_start), 512'd0);
    chk("t5_vin", 512'(o_blk_vin), 512'(IV));
    chk("t5_data", o_blk_data, 512'd0);
    rst_n = 1'b1;
    for (int t = 0; t < 200 && core_busy; t++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("t5_late_done_nohash", 512'(log_hash.size()), 512'd0);
    chk("t5_still_fill", 512'(o_ready), 512'd1);
    log_data.delete(); log_vin.delete(); log_hash.delete();
    core_lat = 4;
    make_abc(); model_msg(); send_msg(0); idle(); wait_hashes(1);
    chk("t5_rerun_digest", 512'(get_h(0)), 512'(256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0));
    check_logs("t5");

    // Back-to-back messages, valid held through PAD/HASH, slow core
    core_lat = 64;
    make_rand(60);  model_msg(); send_msg(1);
    make_rand(5);   model_msg(); send_msg(0);
    make_rand(64);  model_msg(); send_msg(1);
    make_rand(100); model_msg(); send_msg(2);
    idle(); wait_hashes(4);
    check_logs("t6");

    // Random lengths, latencies and gaps
    for (int m = 0; m < 16; m++) begin
      core_lat = $urandom_range(1, 10);
      make_rand($urandom_range(0, 150)); model_msg(); send_msg(2);
      if ($urandom_range(0, 1) == 1) begin
        idle();
        repeat ($urandom_range(0, 5)) @(negedge clk);
      end
      idle(); wait_hashes(1);
      check_logs("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
